// File: rtl/jpeg_dezigzag_pkg.sv
// Shared constants for the inverse zigzag reorder buffer.
// ZZ2RASTER maps a zigzag scan index to its raster (row-major) position in an 8x8 block.
package jpeg_dezigzag_pkg;

    localparam int unsigned BLK_SIZE = 64;
    localparam int unsigned IDX_W    = 6;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_IDX = 6'd63;

    // Entry k is the raster position of zigzag index k.
    localparam idx_t ZZ2RASTER [BLK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Raster address for a given zigzag index.
    function automatic idx_t zz2raster(input idx_t zz_idx);
        return ZZ2RASTER[zz_idx];
    endfunction

endpackage

// File: rtl/jpeg_dezigzag_bank.sv
// One 64-entry coefficient bank: synchronous write port, combinational read port.
// Contents are deliberately not reset; the control logic tracks validity.
module jpeg_dezigzag_bank
    import jpeg_dezigzag_pkg::*;
#(
    parameter int unsigned COEF_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [COEF_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [COEF_W-1:0] o_rdata
);

    logic [COEF_W-1:0] r_mem [BLK_SIZE];

    // Store one coefficient per write strobe.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jpeg_dezigzag_buffer.sv
// Inverse zigzag reorder buffer. Coefficients arrive in zigzag order and are scattered
// into one of two banks at their raster address; full banks drain sequentially in raster
// order through a registered valid/ready output stage. The banks ping-pong so one block
// fills while the previous one drains.
module jpeg_dezigzag_buffer
    import jpeg_dezigzag_pkg::*;
#(
    parameter int unsigned COEF_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [COEF_W-1:0] i_in_data,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [COEF_W-1:0] o_out_data,
    output logic              o_out_last,
    output logic              o_blk_err
);

    // Control state
    logic [1:0]        r_bank_full;
    logic              r_wr_bank;
    idx_t              r_wr_idx;
    logic              r_rd_bank;
    idx_t              r_rd_idx;
    logic              r_out_valid;
    logic [COEF_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_blk_err;

    // Datapath and handshake wires
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_wr_last;
    idx_t              w_wr_addr;
    logic              w_out_adv;
    logic              w_rd_fire;
    logic              w_rd_last;
    logic [1:0]        w_bank_we;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;
    logic [COEF_W-1:0] w_bank_rdata [2];
    logic [COEF_W-1:0] w_rd_data;

    // Accept only into a bank that is not holding an undrained block.
    assign w_in_ready = !r_bank_full[r_wr_bank];
    assign w_in_fire  = i_in_valid && w_in_ready;
    assign w_wr_last  = (r_wr_idx == LAST_IDX);
    assign w_wr_addr  = zz2raster(r_wr_idx);

    // The output register may load whenever it is empty or being consumed.
    assign w_out_adv  = !r_out_valid || i_out_ready;
    assign w_rd_fire  = w_out_adv && r_bank_full[r_rd_bank];
    assign w_rd_last  = (r_rd_idx == LAST_IDX);
    assign w_rd_data  = w_bank_rdata[r_rd_bank];

    // Per-bank write strobes and full-flag set/clear requests.
    always_comb begin
        w_bank_we  = 2'b00;
        w_full_set = 2'b00;
        w_full_clr = 2'b00;
        if (w_in_fire) begin
            w_bank_we[r_wr_bank] = 1'b1;
            if (w_wr_last) begin
                w_full_set[r_wr_bank] = 1'b1;
            end
        end
        if (w_rd_fire && w_rd_last) begin
            w_full_clr[r_rd_bank] = 1'b1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        jpeg_dezigzag_bank #(
            .COEF_W (COEF_W)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_bank_we[g]),
            .i_waddr (w_wr_addr),
            .i_wdata (i_in_data),
            .i_raddr (r_rd_idx),
            .o_rdata (w_bank_rdata[g])
        );
    end

    // Bank-full flags; a set and a clear in one cycle always hit different banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= (r_bank_full | w_full_set) & ~w_full_clr;
        end
    end

    // Write pointer; the 64-count alone defines block boundaries, in_last is only checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
            r_blk_err <= 1'b0;
        end else begin
            r_blk_err <= w_in_fire && (i_in_last != w_wr_last);
            if (w_in_fire) begin
                r_wr_idx <= r_wr_idx + 6'd1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
        end
    end

    // Read pointer and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_idx    <= '0;
            r_rd_bank   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_out_adv) begin
            if (r_bank_full[r_rd_bank]) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rd_data;
                r_out_last  <= w_rd_last;
                r_rd_idx    <= r_rd_idx + 6'd1;
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_blk_err   = r_blk_err;

endmodule

// File: tb/tb_jpeg_dezigzag_buffer.sv
// Self-checking bench for jpeg_dezigzag_buffer. The reference model rebuilds the zigzag
// scan by walking anti-diagonals and reorders each completed 64-coefficient block.
module tb_jpeg_dezigzag_buffer;

    localparam int COEF_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [COEF_W-1:0] i_in_data;
    logic              i_in_last;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [COEF_W-1:0] o_out_data;
    logic              o_out_last;
    logic              o_blk_err;

    always #5 clk = ~clk;

    jpeg_dezigzag_buffer #(
        .COEF_W (COEF_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_last   (i_in_last),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .o_blk_err   (o_blk_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int                zz_tab [64];
    logic [COEF_W:0]   exp_q [$];
    logic [COEF_W-1:0] cur [$];
    logic [COEF_W-1:0] got [64];
    bit                exp_err;
    bit                stall_prev;
    logic [COEF_W-1:0] prev_data;
    logic              prev_last;
    int cyc, n_out, n_acc, n_errp, first_ov, last_in, first_fire, last_fire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_stats();
        n_out = 0; n_acc = 0; n_errp = 0;
        first_ov = -1; last_in = -1; first_fire = -1; last_fire = -1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur.delete();
        exp_err    = 1'b0;
        stall_prev = 1'b0;
    endtask

    // Complete block: place zigzag element z at raster position zz_tab[z].
    task automatic model_push_block();
        logic [COEF_W-1:0] ras [64];
        for (int z = 0; z < 64; z++) ras[zz_tab[z]] = cur[z];
        for (int r = 0; r < 64; r++) exp_q.push_back({(r == 63), ras[r]});
        cur.delete();
    endtask

    // One clock cycle; entered and left at a falling edge with inputs already driven.
    task automatic cycle();
        bit in_fire, out_fire;
        logic [COEF_W:0] e;
        in_fire  = i_in_valid && o_in_ready;
        out_fire = o_out_valid && i_out_ready;
        chk("blk_err", {31'b0, o_blk_err}, {31'b0, exp_err});
        n_errp += int'(o_blk_err);
        if (stall_prev) begin
            chk("hold_valid", {31'b0, o_out_valid}, 32'd1);
            chk("hold_data", {20'b0, o_out_data}, {20'b0, prev_data});
            chk("hold_last", {31'b0, o_out_last}, {31'b0, prev_last});
        end
        if (o_out_valid && first_ov < 0) first_ov = cyc;
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", {31'b0, o_out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {20'b0, o_out_data}, {20'b0, e[COEF_W-1:0]});
                chk("out_last", {31'b0, o_out_last}, {31'b0, e[COEF_W]});
            end
            got[n_out % 64] = o_out_data;
            n_out++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
        end
        exp_err = in_fire && (i_in_last != (cur.size() == 63));
        if (in_fire) begin
            cur.push_back(i_in_data);
            if (cur.size() == 64) model_push_block();
            n_acc++;
            last_in = cyc;
        end
        stall_prev = o_out_valid && !i_out_ready;
        prev_data  = o_out_data;
        prev_last  = o_out_last;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Offer one coefficient until it is accepted.
    task automatic send(input logic [COEF_W-1:0] d, input logic l);
        int a, g;
        i_in_valid = 1'b1;
        i_in_data  = d;
        i_in_last  = l;
        a = n_acc;
        for (g = 0; g < 2000 && n_acc == a; g++) cycle();
        if (n_acc == a) chk("send_timeout", n_acc, a + 1);
    endtask

    task automatic drain(input int bound);
        i_in_valid  = 1'b0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b1;
        for (int g = 0; g < bound && (exp_q.size() != 0 || o_out_valid); g++) cycle();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo, hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz_tab[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz_tab[k] = r * 8 + (s - r); k++; end
            end
        end

        rst_n = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_in_last = 1'b0; i_out_ready = 1'b0;
        cyc = 0;
        model_reset();
        clear_stats();
        #3;
        chk("rst_in_ready", {31'b0, o_in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
        chk("rst_out_last", {31'b0, o_out_last}, 32'd0);
        chk("rst_blk_err", {31'b0, o_blk_err}, 32'd0);
        chk("rst_out_data", {20'b0, o_out_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single block, value = zigzag index.
        clear_stats();
        i_out_ready = 1'b1;
        for (int z = 0; z < 64; z++) send(COEF_W'(z), z == 63);
        drain(300);
        chk("t1_count", n_out, 64);
        chk("t1_latency", first_ov - last_in, 2);
        chk("t1_r0", {20'b0, got[0]}, 0);
        chk("t1_r1", {20'b0, got[1]}, 1);
        chk("t1_r2", {20'b0, got[2]}, 5);
        chk("t1_r8", {20'b0, got[8]}, 2);
        chk("t1_r16", {20'b0, got[16]}, 3);
        chk("t1_r63", {20'b0, got[63]}, 63);

        // Back-to-back streaming of four blocks.
        clear_stats();
        i_out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            chk("t2_in_ready", {31'b0, o_in_ready}, 32'd1);
            send(COEF_W'($urandom_range(0, 4095)), (i % 64) == 63);
        end
        drain(400);
        chk("t2_count", n_out, 256);
        chk("t2_contiguous", last_fire - first_fire, 255);

        // Backpressure: two blocks fill both banks while the output is stalled.
        clear_stats();
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        for (int i = 0; i < 140; i++) begin
            i_in_data = COEF_W'($urandom_range(0, 4095));
            i_in_last = (cur.size() == 63);
            cycle();
        end
        chk("t3_accepted", n_acc, 128);
        chk("t3_in_ready_low", {31'b0, o_in_ready}, 32'd0);
        chk("t3_stalled_valid", {31'b0, o_out_valid}, 32'd1);
        drain(400);
        chk("t3_count", n_out, 128);
        chk("t3_in_ready_back", {31'b0, o_in_ready}, 32'd1);

        // Framing errors: early in_last at 40, missing in_last at 63.
        clear_stats();
        i_out_ready = 1'b1;
        for (int z = 0; z < 64; z++) send(COEF_W'($urandom_range(0, 4095)), z == 40);
        drain(300);
        chk("t4_err_pulses", n_errp, 2);
        chk("t4_count", n_out, 64);

        // Reset while block 0 drains and block 1 is partially written.
        clear_stats();
        i_out_ready = 1'b1;
        for (int z = 0; z < 94; z++) send(COEF_W'($urandom_range(0, 4095)), z == 63);
        chk("t5_draining", {31'b0, o_out_valid}, 32'd1);
        i_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", {31'b0, o_out_valid}, 32'd0);
        chk("t5_rst_in_ready", {31'b0, o_in_ready}, 32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        for (int z = 0; z < 64; z++) send(COEF_W'(z), z == 63);
        drain(300);
        chk("t5_count", n_out, 64);
        chk("t5_r2", {20'b0, got[2]}, 5);
        chk("t5_r16", {20'b0, got[16]}, 3);
        chk("t5_r63", {20'b0, got[63]}, 63);

        // Random stress over 1000 blocks with random duty cycles and rare framing errors.
        clear_stats();
        for (int g = 0; g < 95000 && n_acc < 64000; g++) begin
            i_in_valid  = ($urandom_range(0, 15) != 0);
            i_in_data   = COEF_W'($urandom_range(0, 4095));
            i_in_last   = (cur.size() == 63) ^ ($urandom_range(0, 99) == 0);
            i_out_ready = ($urandom_range(0, 7) != 0);
            cycle();
        end
        chk("t6_accepted", n_acc, 64000);
        drain(1000);
        chk("t6_count", n_out, 64000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_dezigzag_buffer.md
# jpeg_dezigzag_buffer

Inverse zigzag reorder buffer: the read-side counterpart of the `fdct_zigzag` output stage. It accepts 8x8 blocks of quantised DCT coefficients in zigzag order, one per accepted handshake. It emits each block in raster (row-major) order with full valid/ready backpressure. Two 64-entry banks ping-pong, so one block is written while the previous one drains. It sits in the decode/verification path ahead of the IDCT MAC array.

## Interface

Parameters:
- `COEF_W`, 12: coefficient width in bits, two's complement. Stored and passed through unmodified.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  input coefficient valid.
- `in_ready`  out  1  buffer can accept an input coefficient.
- `in_data`  in  COEF_W  coefficient, zigzag order.
- `in_last`  in  1  marks zigzag index 63; advisory only.
- `out_valid`  out  1  output coefficient valid.
- `out_ready`  in  1  downstream accepts the output coefficient.
- `out_data`  out  COEF_W  coefficient, raster order.
- `out_last`  out  1  high with raster index 63.
- `blk_err`  out  1  one-cycle pulse on an `in_last` framing mismatch.

## Operation

**State**
- Banks `bank[0..1][0..63]`, each COEF_W wide.
- Flags `bank_full[1:0]`.
- Write side: `wr_bank`, `wr_idx[5:0]`.
- Read side: `rd_bank`, `rd_idx[5:0]`.
- Output register: `out_valid`, `out_data`, `out_last`.

**Write side**
- `in_ready = !bank_full[wr_bank]`.
- On `in_valid && in_ready`:
  - `bank[wr_bank][ZZ2RASTER[wr_idx]] <= in_data`.
  - `wr_idx` increments and wraps 63 -> 0.
- On acceptance at `wr_idx == 63`: set `bank_full[wr_bank]` and toggle `wr_bank`.
- Block boundary is fixed by the count of 64; `in_last` never shortens or extends a block.
- `blk_err` pulses for one cycle in either case:
  - `in_last` = 1 at `wr_idx != 63`;
  - `in_last` = 0 at `wr_idx == 63`.

**Read side**
- The output register advances when `!out_valid || out_ready`.
- On advance with `bank_full[rd_bank]`:
  - `out_data <= bank[rd_bank][rd_idx]`;
  - `out_last <= (rd_idx == 63)`;
  - `out_valid <= 1`;
  - `rd_idx` increments.
- On loading `rd_idx == 63`: clear `bank_full[rd_bank]` and toggle `rd_bank`.
- On advance with no full bank: `out_valid <= 0`.

**Bank flag rules**
- Set and clear of `bank_full` in the same cycle always target different banks, because a write requires the bank to be not full. Both take effect.
- Both banks full: `in_ready` = 0 until the read side drains a bank.

**Reset** (any time, including mid-block): every flag, index and bank pointer clears to 0.
- Partial blocks are discarded.
- Bank contents are not reset.

## Timing

Reset values:
- `in_ready` = 1.
- `out_valid`, `out_last`, `blk_err` = 0.
- `out_data` = 0.

Latency and throughput:
- `out_valid` first rises 2 cycles after the handshake cycle of input index 63.
- Sustained throughput is 1 coefficient per cycle in each direction.
- With `out_ready` held high and `in_valid` held high, there are no bubbles after the first block.

Handshake rules:
- `out_data` and `out_last` are held stable while `out_valid && !out_ready`.
- `in_ready` depends only on registered state; there is no combinational path from `in_valid`.
- `blk_err` is registered and asserts the cycle after the offending handshake.

## Structure

Package `jpeg_dezigzag_pkg` holds:
- `ZZ2RASTER`: a 64-entry constant array of 6-bit values, where entry k is the raster position of zigzag index k. Begins 0,1,8,16,9,2,3,10,17,24 and ends at 63.
- `BLK_SIZE = 64` and `IDX_W = 6`.

Sub-module `jpeg_dezigzag_bank`: one 64 x COEF_W register bank with one write port and one combinational read port, instantiated twice. All control stays in the top.

## Test plan

- **Single block mapping.** Stimulus: one block with value = zigzag index (0..63) and `out_ready` = 1. Required response, in raster order:
  - raster 0, 1, 2, 8, 16, 63 carry values 0, 1, 5, 2, 3, 63;
  - `out_last` is high only on the 64th output;
  - first `out_valid` appears 2 cycles after the 64th input handshake.
- **Back-to-back streaming.** Stimulus: 4 consecutive blocks with `in_valid` and `out_ready` held high. Required response:
  - `in_ready` never drops after reset;
  - 256 outputs on consecutive cycles;
  - block order preserved.
- **Backpressure.** Stimulus: `out_ready` = 0 while 2 blocks are offered. Required response:
  - `in_ready` falls to 0 after 128 accepted inputs;
  - `out_data` is stable while stalled;
  - releasing `out_ready` drains both blocks correctly, then `in_ready` returns to 1.
- **Framing error.** Stimulus: `in_last` = 1 at index 40, then `in_last` = 0 at index 63. Required response: exactly 2 `blk_err` pulses, and the block is still output complete and correctly ordered.
- **Reset mid-operation.** Stimulus: assert `rst_n` low after 30 inputs of block 1, while block 0 is draining. Required response:
  - `out_valid` = 0 and `in_ready` = 1 immediately;
  - after release, a fresh block maps correctly from index 0.
- **Random stress.** Stimulus: random `in_valid`/`out_ready` duty cycles over 1000 blocks. Required response: a scoreboard against `ZZ2RASTER` shows no loss, duplication or reorder.
